// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants.
// Holds the instruction width and the default reset PC / PC increment used by
// the fetch stage, so every block that deals with instruction addresses agrees
// on them.
package mips_pkg;

  localparam int INST_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_WIDTH-1:0] PC_INC_DEFAULT   = 32'h0000_0004;

  localparam int FETCH_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue storage for the fetch stage.
// A DEPTH-entry circular buffer of DW-bit entries with an occupancy counter.
// Ports:
//   clk, rst       - rising-edge clock, synchronous active-high reset
//   flush          - synchronous clear of pointers and count (contents kept)
//   push/push_data - write one entry at the tail (ignored when full)
//   pop            - retire the head entry (ignored when empty)
//   head_data      - entry at the head pointer
//   count/full/empty - occupancy status
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DW    = 2 * INST_WIDTH,
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];

  // Qualified handshakes: never overrun a full queue or underrun an empty one.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; not cleared on reset, only ever read below count.
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a small prefetch queue feeding IF/ID.
// Owns the PC and the fetch/pop/redirect control; storage lives in fetch_fifo.
// Ports:
//   clk, rst                  - rising-edge clock, synchronous active-high reset
//   inst_adr, inst_req        - fetch address / request to instruction memory
//   inst_ready, inst          - memory accept and returned instruction word
//   redirect, redirect_pc     - taken branch/jump and its target
//   stall                     - decode is not consuming this cycle
//   ifid_inst/pc4/valid       - head instruction, its PC+PC_INC, presence flag
//   count, full, empty        - queue occupancy
module fetch_queue
  import mips_pkg::*;
#(
  parameter int               WIDTH    = INST_WIDTH,
  parameter int               DEPTH    = FETCH_DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(PC_INC_DEFAULT),
  localparam int              CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] inst_adr,
  output logic             inst_req,
  input  logic             inst_ready,
  input  logic [WIDTH-1:0] inst,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic [WIDTH-1:0] ifid_inst,
  output logic [WIDTH-1:0] ifid_pc4,
  output logic             ifid_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]   pc_r;
  logic [WIDTH-1:0]   pc_next_s;
  logic               fire_s;
  logic               pop_s;
  logic [2*WIDTH-1:0] head_s;

  assign inst_adr   = pc_r;
  assign ifid_valid = !empty;

  // Request and handshake decode; redirect blocks both fetch and pop so
  // nothing from the wrong path is queued or consumed.
  always_comb begin
    inst_req = !full && !redirect && !rst;
    fire_s   = inst_req && inst_ready;
    pop_s    = ifid_valid && !stall && !redirect;
  end

  // PC next-state: redirect outranks a normal advance, otherwise hold.
  always_comb begin
    if (redirect) begin
      pc_next_s = redirect_pc;
    end else if (fire_s) begin
      pc_next_s = pc_r + PC_INC;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  fetch_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fire_s),
    .push_data ({inst, pc_r + PC_INC}),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Head presentation; stale storage must never leak out when empty.
  always_comb begin
    if (ifid_valid) begin
      ifid_inst = head_s[2*WIDTH-1:WIDTH];
      ifid_pc4  = head_s[WIDTH-1:0];
    end else begin
      ifid_inst = {WIDTH{1'b0}};
      ifid_pc4  = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model predicts
// PC, request and occupancy; every predicted fetch goes into a scoreboard that
// an independent monitor drains whenever the DUT hands an entry to decode.
module tb_fetch_queue;
  import mips_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_adr;
  logic        inst_req;
  logic        inst_ready = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  // Second instance with a reset PC just below the top of the address space.
  logic        rst2 = 1'b1;
  logic [31:0] inst_adr2;
  logic        inst_req2;
  logic [31:0] ifid_inst2;
  logic [31:0] ifid_pc42;
  logic        ifid_valid2;
  logic [2:0]  count2;
  logic        full2;
  logic        empty2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mdl_q[$];
  logic [63:0] sb_q[$];
  logic [31:0] mdl_pc = RPC;

  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RPC), .PC_INC(32'd4)) dut (
    .clk(clk), .rst(rst), .inst_adr(inst_adr), .inst_req(inst_req),
    .inst_ready(inst_ready), .inst(inst), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .ifid_inst(ifid_inst),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .count(count),
    .full(full), .empty(empty)
  );

  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RPC2), .PC_INC(32'd4)) dut2 (
    .clk(clk), .rst(rst2), .inst_adr(inst_adr2), .inst_req(inst_req2),
    .inst_ready(1'b1), .inst(32'h0), .redirect(1'b0),
    .redirect_pc(32'h0), .stall(1'b0), .ifid_inst(ifid_inst2),
    .ifid_pc4(ifid_pc42), .ifid_valid(ifid_valid2), .count(count2),
    .full(full2), .empty(empty2)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, check predicted front-end state,
  // then advance the reference model past the rising edge.
  task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic st, input logic rdy, input logic [31:0] in);
    logic        exp_req;
    logic        fire;
    logic        pop;
    logic [63:0] ent;
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rpc; stall = st; inst_ready = rdy; inst = in;
    #1;
    exp_req = (mdl_q.size() < DEPTH) && !rd && !r;
    chk("inst_req", 64'(inst_req), 64'(exp_req));
    chk("inst_adr", 64'(inst_adr), 64'(mdl_pc));
    chk("count", 64'(count), 64'(mdl_q.size()));
    chk("full", 64'(full), 64'(mdl_q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(mdl_q.size() == 0));
    fire = exp_req && rdy;
    pop  = (mdl_q.size() != 0) && !st && !rd && !r;
    @(posedge clk);
    #1;
    if (r) begin
      mdl_q.delete(); sb_q.delete(); mdl_pc = RPC;
    end else if (rd) begin
      mdl_q.delete(); sb_q.delete(); mdl_pc = rpc;
    end else begin
      if (pop) void'(mdl_q.pop_front());
      if (fire) begin
        ent = {in, mdl_pc + 32'd4};
        mdl_q.push_back(ent);
        sb_q.push_back(ent);
        mdl_pc = mdl_pc + 32'd4;
      end
    end
  endtask

  // Monitor: observes the decode-side handshake and drains the scoreboard.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    #2;
    chk("ifid_valid", 64'(ifid_valid), 64'(sb_q.size() != 0));
    if (ifid_valid && !stall && !redirect && !rst) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_underflow: DUT popped 0x%0h with no expected entry", ifid_inst);
      end else begin
        e = sb_q.pop_front();
        chk("ifid_inst", 64'(ifid_inst), 64'(e[63:32]));
        chk("ifid_pc4", 64'(ifid_pc4), 64'(e[31:0]));
      end
    end else if (!ifid_valid) begin
      chk("ifid_inst_zero", 64'(ifid_inst), 64'd0);
      chk("ifid_pc4_zero", 64'(ifid_pc4), 64'd0);
    end else if (sb_q.size() != 0) begin
      chk("ifid_head_inst", 64'(ifid_inst), 64'(sb_q[0][63:32]));
    end else begin
      e = 64'd0;
    end
  end

  // Main stimulus sequence.
  initial begin
    // Reset-PC wrap on the second instance, continuous fetch with no stall.
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("wrap_adr0", 64'(inst_adr2), 64'hFFFF_FFF8);
    chk("wrap_req0", 64'(inst_req2), 64'd1);
    @(negedge clk); #1;
    chk("wrap_adr1", 64'(inst_adr2), 64'hFFFF_FFFC);
    chk("wrap_pc4_0", 64'(ifid_pc42), 64'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_adr2", 64'(inst_adr2), 64'h0);
    chk("wrap_pc4_1", 64'(ifid_pc42), 64'h0);

    // Reset, then a single fetch reaching decode one cycle later.
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2008_0005);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Fill under stall until full, hold, then drain in order.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, $urandom);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Redirect with three queued entries, then fetch from the target.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, $urandom);
    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1, $urandom);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, $urandom);

    // Alternating memory ready with decode consuming.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'(i % 2 == 0), $urandom);

    // Reset arriving together with a redirect while two entries are queued.
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, $urandom);
    cycle(1'b1, 1'b1, 32'h0000_0800, 1'b0, 1'b1, $urandom);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 5),
            $urandom, 1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 70),
            $urandom);
    end

    @(negedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WIDTH, 32, address/instruction width in bits; SHALL be >= 8.
REQ-002 Parameter DEPTH, 4, prefetch queue entries; SHALL be a power of two, >= 2.
REQ-003 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-004 Parameter PC_INC, 4, PC increment per fetched instruction.
REQ-005 One clock; reset is synchronous and active-high; ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-006 inst_adr out WIDTH, current fetch PC to instruction memory.
REQ-007 inst_req out 1, fetch request; inst_ready in 1, memory accepts request this cycle; inst in WIDTH, instruction word, valid when inst_req && inst_ready.
REQ-008 redirect in 1, taken branch/jump; redirect_pc in WIDTH, target address.
REQ-009 stall in 1, decode stage not consuming this cycle.
REQ-010 ifid_inst out WIDTH, head instruction; ifid_pc4 out WIDTH, head PC+PC_INC; ifid_valid out 1, head entry present.
REQ-011 count out clog2(DEPTH+1), occupied entries; full out 1; empty out 1.

Function
REQ-012 Fetch fires when inst_req && inst_ready; on fire, {inst, inst_adr+PC_INC} SHALL be written at tail and PC SHALL advance by PC_INC.
REQ-013 inst_req SHALL be 1 iff !full && !redirect && !rst.
REQ-014 Pop fires when ifid_valid && !stall && !redirect; head pointer SHALL advance one entry.
REQ-015 Push and pop in the same cycle SHALL leave count unchanged.
REQ-016 Latency: instruction fetched in cycle N into an empty queue SHALL appear on ifid_* with ifid_valid=1 in cycle N+1; no combinational bypass from inst to ifid_*.
REQ-017 ifid_inst and ifid_pc4 SHALL be driven to 0 whenever ifid_valid=0.
REQ-018 ifid_valid = !empty; empty = (count==0); full = (count==DEPTH).
REQ-019 Head/tail pointers SHALL wrap modulo DEPTH; PC arithmetic SHALL wrap modulo 2^WIDTH.
REQ-020 Redirect has highest priority: next cycle count=0, pointers equal, PC=redirect_pc; same-cycle fetch and pop SHALL be suppressed.
REQ-021 Redirect while full or empty SHALL behave identically to REQ-020.
REQ-022 stall with empty queue SHALL have no effect; stall with full queue SHALL hold inst_req=0 until a pop.
REQ-023 inst_ready=0 SHALL hold PC and queue tail unchanged.

Reset
REQ-024 On rst=1 at a clk edge: PC=RESET_PC, head=tail=0, count=0, so ifid_valid=0, ifid_inst=0, ifid_pc4=0, empty=1, full=0, inst_req=0 during reset.
REQ-025 Reset SHALL override redirect, push and pop in the same cycle; storage array need not be cleared.
REQ-026 First fetch after reset deassertion SHALL present inst_adr=RESET_PC.

Structure
REQ-027 RESET_PC default, PC_INC default and instruction width constant SHALL live in the shared mips_pkg constants file.
REQ-028 Queue storage and pointers SHALL be one sub-module, fetch_fifo (parametrised WIDTH*2 data, DEPTH, with flush input); PC register and control stay in fetch_queue.

Verification
REQ-029 Reset, inst_ready=1, stall=0, inst=0x20080005 -> cycle 1 inst_adr=0x0, cycle 2 ifid_inst=0x20080005, ifid_pc4=0x4, ifid_valid=1.
REQ-030 stall=1, inst_ready=1, DEPTH=4 -> after 4 fires full=1, count=4, inst_req=0, inst_adr=0x10; release stall -> pops in order pc4=0x4,0x8,0xC,0x10.
REQ-031 Queue holding 3 entries, redirect=1 with redirect_pc=0x400 -> next cycle count=0, ifid_valid=0, inst_adr=0x400; following fetch yields ifid_pc4=0x404.
REQ-032 Alternating inst_ready 1/0 with stall=0 -> count never exceeds 1, PC advances only on fire cycles, no entry lost or duplicated.
REQ-033 RESET_PC=0xFFFFFFF8, continuous fetch -> inst_adr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0; ifid_pc4 for second entry=0x0.
REQ-034 rst asserted mid-operation with count=2 and redirect=1 -> next cycle count=0, inst_adr=RESET_PC, ifid_inst=0.
